frogger_input_ctrl: RTL and testbench
=====================================

Name: frogger_input_ctrl

Overview:
Produces the four movement strobes that the frog controller consumes (up/down/left/right). It takes raw board switches and synchronises and debounces them. It arbitrates simultaneous presses with the same priority as the frog controller and generates hold-to-repeat moves. It sits between the top-level switch pins and the frog controller.

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive clocks a raw level must persist before the debounced state changes (10 ms at 25 MHz)
REPEAT_DELAY, 12500000, clocks from first move pulse to first auto-repeat pulse (500 ms)
REPEAT_PERIOD, 5000000, clocks between subsequent auto-repeat pulses (200 ms)

Ports:
i_Clk  input  1  system clock
i_Rst  input  1  reset, asynchronous, active-high
i_Switch_1  input  1  raw up switch, asynchronous to i_Clk
i_Switch_2  input  1  raw down switch
i_Switch_3  input  1  raw left switch
i_Switch_4  input  1  raw right switch
i_Game_Active  input  1  moves are generated only while high
i_Collided  input  1  collision or death indication from the game logic
o_Up_Mvt  output  1  one-cycle move-up strobe
o_Down_Mvt  output  1  one-cycle move-down strobe
o_Left_Mvt  output  1  one-cycle move-left strobe
o_Right_Mvt  output  1  one-cycle move-right strobe
o_Any_Held  output  1  OR of the four debounced switch states (registered)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0, debounced states 0. Reset is applied asynchronously and released synchronously with i_Clk.
- Per switch:
  - 2-flop synchroniser.
  - A debounce counter increments while the synced level differs from the debounced state and clears when they match.
  - When the counter reaches DEBOUNCE_LIMIT-1, the debounced state flips and the counter clears.
- Debounced rising edge = debounced state is 1 and its previous-cycle value is 0.
- Latency from a raw press to the move strobe: 2 (sync) + DEBOUNCE_LIMIT + 1 (registered output) cycles.
- Strobe properties:
  - Strobes are exactly 1 cycle wide.
  - At most one strobe is high in any cycle.
  - Each strobe is followed by at least one low cycle, so the consumer's rising-edge detector sees every strobe.
- Priority on simultaneous debounced rising edges in the same cycle: up > down > left > right.
- FSM states: IDLE, DELAY, REPEAT, LOCKOUT. A 2-bit latched direction is held alongside the state.
  - IDLE: on a debounced rising edge (after priority selection), pulse that direction, latch it, clear the timer, go to DELAY.
  - DELAY: if the latched switch is released, go to IDLE. When the timer reaches REPEAT_DELAY-1, pulse the latched direction, clear the timer, go to REPEAT.
  - REPEAT: if the latched switch is released, go to IDLE. When the timer reaches REPEAT_PERIOD-1, pulse and clear the timer.
  - LOCKOUT: no pulses. Go to IDLE in the first cycle in which all four debounced states are 0.
- Other switches pressed or held during DELAY/REPEAT are ignored. After a return to IDLE, a switch that is still held does not fire; only a new debounced rising edge fires.
- Collision: i_Collided high in any state goes to LOCKOUT next cycle and suppresses any pulse in that cycle. This prevents a held key from moving the frog immediately after respawn.
- Game inactive: i_Game_Active low forces IDLE and suppresses pulses in that cycle. Debouncers keep running. If both i_Collided and inactive apply, LOCKOUT wins.
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). The timer never wraps; it is cleared on every pulse and every state change.
- Debounce counter width: $clog2(DEBOUNCE_LIMIT). It saturates by construction and never wraps.
- Reset asserted mid-DELAY/REPEAT: outputs go to 0 immediately, without waiting for a clock edge.

Decomposition:
- Shared package:
  - direction encoding DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3
  - FSM state encoding
  - default timing constants for the 25 MHz board clock
- Sub-module switch_debounce: one instance per switch. Contains the synchroniser, debounce counter, debounced state output and rising-edge output. Parameter: DEBOUNCE_LIMIT.

Test Plan:
All scenarios use DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; each names the stimulus, then the required response.
1. Clean press of i_Switch_1 at cycle 0, held → o_Up_Mvt high for exactly cycle 7 only. Release before cycle 27 → no further pulses.
2. i_Switch_2 glitch high for 3 cycles, then low → no strobe ever. Debounced state stays 0.
3. i_Switch_4 held for 60 cycles → o_Right_Mvt pulses at cycles 7, 27, 35, 43, 51, 59, then none once the debounced release is seen.
4. i_Switch_1 and i_Switch_3 rise in the same cycle → only o_Up_Mvt at cycle 7. Release up with left still held → no left strobe. Release and re-press left → left strobe after 7 cycles.
5. Hold i_Switch_2 and pulse i_Collided at cycle 15 → no strobes from cycle 16 onward while held. Release, then re-press → strobe 7 cycles after re-press.
6. Pulse i_Rst asynchronously mid-REPEAT, between clock edges → all strobes 0 immediately. After release, a held switch does not fire until it is re-pressed.

Source files
------------

// File: rtl/frogger_input_ctrl_pkg.sv
// Shared definitions for the frogger input controller: direction codes, FSM states,
// board timing defaults and small helpers used by the controller and its debouncers.
package frogger_input_ctrl_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // 25 MHz board clock: 10 ms debounce, 500 ms first repeat, 200 ms repeat period
    localparam int DEF_DEBOUNCE_LIMIT = 250000;
    localparam int DEF_REPEAT_DELAY   = 12500000;
    localparam int DEF_REPEAT_PERIOD  = 5000000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Same priority as the frog controller: up > down > left > right
    function automatic logic [1:0] pick_dir(input logic [3:0] rise);
        if (rise[DIR_UP])
            return DIR_UP;
        else if (rise[DIR_DOWN])
            return DIR_DOWN;
        else if (rise[DIR_LEFT])
            return DIR_LEFT;
        else
            return DIR_RIGHT;
    endfunction

    function automatic logic [3:0] dir_mask(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/frogger_input_ctrl_switch_debounce.sv
// One board switch: 2-flop synchroniser, persistence-count debouncer and a
// qualified rising-edge output for the move arbiter.
module switch_debounce
    import frogger_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
)
(
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_State,
    output logic o_Rise
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             r_Sync_1;
    logic             r_Sync_2;
    logic [CNT_W-1:0] r_Count;
    logic             r_State;
    logic             r_State_Prev;
    logic [1:0]       r_Fill;
    logic             r_Armed;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Sync_1     <= 1'b0;
            r_Sync_2     <= 1'b0;
            r_Count      <= '0;
            r_State      <= 1'b0;
            r_State_Prev <= 1'b0;
            r_Fill       <= 2'b00;
            r_Armed      <= 1'b0;
        end else begin
            r_Sync_1     <= i_Switch;
            r_Sync_2     <= r_Sync_1;
            r_State_Prev <= r_State;
            r_Fill       <= {r_Fill[0], 1'b1};
            // A switch held through reset must be seen released before it may fire
            if (r_Fill[1] && !r_Sync_2)
                r_Armed <= 1'b1;
            if (r_Sync_2 == r_State) begin
                r_Count <= '0;
            end else if (r_Count == CNT_LAST) begin
                r_State <= r_Sync_2;
                r_Count <= '0;
            end else begin
                r_Count <= r_Count + CNT_W'(1);
            end
        end
    end

    assign o_State = r_State;
    assign o_Rise  = r_State & ~r_State_Prev & r_Armed;

endmodule

// File: rtl/frogger_input_ctrl.sv
// Turns four raw board switches into one-cycle, mutually exclusive move strobes
// with priority arbitration, hold-to-repeat and post-collision lockout.
module frogger_input_ctrl
    import frogger_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD
)
(
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    input  logic i_Game_Active,
    input  logic i_Collided,
    output logic o_Up_Mvt,
    output logic o_Down_Mvt,
    output logic o_Left_Mvt,
    output logic o_Right_Mvt,
    output logic o_Any_Held
);

    localparam int               TMR_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               TMR_W       = cnt_width(TMR_MAX);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic [3:0]       w_Switch;
    logic [3:0]       w_State;
    logic [3:0]       w_Rise;

    state_t           r_State;
    state_t           w_Next_State;
    logic [1:0]       r_Dir;
    logic [1:0]       w_Next_Dir;
    logic [TMR_W-1:0] r_Timer;
    logic [TMR_W-1:0] w_Next_Timer;
    logic             w_Fire;
    logic [3:0]       r_Mvt;
    logic             r_Any_Held;

    assign w_Switch = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < 4; g++) begin : g_deb
        switch_debounce #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_deb (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Switch (w_Switch[g]),
            .o_State  (w_State[g]),
            .o_Rise   (w_Rise[g])
        );
    end

    always_comb begin
        w_Next_State = r_State;
        w_Next_Dir   = r_Dir;
        w_Next_Timer = r_Timer + TMR_W'(1);
        w_Fire       = 1'b0;
        case (r_State)
            ST_IDLE: begin
                w_Next_Timer = '0;
                if (|w_Rise) begin
                    w_Fire       = 1'b1;
                    w_Next_Dir   = pick_dir(w_Rise);
                    w_Next_State = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!w_State[r_Dir]) begin
                    w_Next_State = ST_IDLE;
                    w_Next_Timer = '0;
                end else if (r_Timer == DELAY_LAST) begin
                    w_Fire       = 1'b1;
                    w_Next_Timer = '0;
                    w_Next_State = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (!w_State[r_Dir]) begin
                    w_Next_State = ST_IDLE;
                    w_Next_Timer = '0;
                end else if (r_Timer == PERIOD_LAST) begin
                    w_Fire       = 1'b1;
                    w_Next_Timer = '0;
                end
            end
            ST_LOCKOUT: begin
                w_Next_Timer = '0;
                if (w_State == 4'b0000)
                    w_Next_State = ST_IDLE;
            end
            default: begin
                w_Next_State = ST_IDLE;
                w_Next_Timer = '0;
            end
        endcase

        // Collision outranks game-inactive so a held key cannot move a respawned frog
        if (i_Collided) begin
            w_Next_State = ST_LOCKOUT;
            w_Next_Dir   = r_Dir;
            w_Next_Timer = '0;
            w_Fire       = 1'b0;
        end else if (!i_Game_Active) begin
            w_Next_State = ST_IDLE;
            w_Next_Dir   = r_Dir;
            w_Next_Timer = '0;
            w_Fire       = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State    <= ST_IDLE;
            r_Dir      <= DIR_UP;
            r_Timer    <= '0;
            r_Mvt      <= 4'b0000;
            r_Any_Held <= 1'b0;
        end else begin
            r_State    <= w_Next_State;
            r_Dir      <= w_Next_Dir;
            r_Timer    <= w_Next_Timer;
            r_Mvt      <= w_Fire ? dir_mask(w_Next_Dir) : 4'b0000;
            r_Any_Held <= |w_State;
        end
    end

    assign o_Up_Mvt    = r_Mvt[DIR_UP];
    assign o_Down_Mvt  = r_Mvt[DIR_DOWN];
    assign o_Left_Mvt  = r_Mvt[DIR_LEFT];
    assign o_Right_Mvt = r_Mvt[DIR_RIGHT];
    assign o_Any_Held  = r_Any_Held;

endmodule

// File: tb/tb_frogger_input_ctrl.sv
// Scoreboard bench for frogger_input_ctrl with short debounce/repeat timings.
module tb_frogger_input_ctrl;
    import frogger_input_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
    logic game_active = 1'b1;
    logic collided = 1'b0;
    logic up_mvt, down_mvt, left_mvt, right_mvt, any_held;

    frogger_input_ctrl #(
        .DEBOUNCE_LIMIT (4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Switch_1    (sw1),
        .i_Switch_2    (sw2),
        .i_Switch_3    (sw3),
        .i_Switch_4    (sw4),
        .i_Game_Active (game_active),
        .i_Collided    (collided),
        .o_Up_Mvt      (up_mvt),
        .o_Down_Mvt    (down_mvt),
        .o_Left_Mvt    (left_mvt),
        .o_Right_Mvt   (right_mvt),
        .o_Any_Held    (any_held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mon_vec;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push_exp(input int c, input logic [1:0] dir);
        exp_t e;
        e.cyc = c;
        e.vec = 1 << dir;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every strobe seen must match the head of the expectation queue
    always @(negedge clk) begin
        mon_vec = {28'd0, right_mvt, left_mvt, down_mvt, up_mvt};
        if (mon_vec != 0) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_strobe", mon_vec, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("strobe_cyc", cyc, mon_e.cyc);
                check_eq("strobe_dir", mon_vec, mon_e.vec);
            end
        end
    end

    initial begin
        int t0;
        int t1;

        // Reset state
        wait_cyc(3);
        check_eq("rst_up", int'(up_mvt), 0);
        check_eq("rst_down", int'(down_mvt), 0);
        check_eq("rst_left", int'(left_mvt), 0);
        check_eq("rst_right", int'(right_mvt), 0);
        check_eq("rst_any", int'(any_held), 0);
        rst = 1'b0;
        wait_cyc(5);

        // 1: clean up press, released before the first repeat
        t0 = cyc;
        sw1 = 1'b1;
        push_exp(t0 + 7, DIR_UP);
        wait_cyc(8);
        check_eq("s1_any_held", int'(any_held), 1);
        wait_cyc(7);
        sw1 = 1'b0;
        wait_cyc(40);
        check_eq("s1_any_released", int'(any_held), 0);
        check_eq("s1_queue", exp_q.size(), 0);

        // 2: three-cycle glitch on down never debounces
        sw2 = 1'b1;
        wait_cyc(3);
        sw2 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            wait_cyc(1);
            check_eq("s2_glitch_any", int'(any_held), 0);
        end

        // 3: right held for 60 cycles with auto-repeat
        t0 = cyc;
        sw4 = 1'b1;
        push_exp(t0 + 7, DIR_RIGHT);
        push_exp(t0 + 27, DIR_RIGHT);
        push_exp(t0 + 35, DIR_RIGHT);
        push_exp(t0 + 43, DIR_RIGHT);
        push_exp(t0 + 51, DIR_RIGHT);
        push_exp(t0 + 59, DIR_RIGHT);
        wait_cyc(60);
        sw4 = 1'b0;
        wait_cyc(30);
        check_eq("s3_queue", exp_q.size(), 0);

        // 4: up and left together, up wins; left needs a fresh press
        t0 = cyc;
        sw1 = 1'b1;
        sw3 = 1'b1;
        push_exp(t0 + 7, DIR_UP);
        wait_cyc(12);
        sw1 = 1'b0;
        wait_cyc(18);
        check_eq("s4_left_held", int'(any_held), 1);
        sw3 = 1'b0;
        wait_cyc(10);
        t1 = cyc;
        sw3 = 1'b1;
        push_exp(t1 + 7, DIR_LEFT);
        wait_cyc(12);
        sw3 = 1'b0;
        wait_cyc(12);
        check_eq("s4_queue", exp_q.size(), 0);

        // 5: collision locks out a held down switch until re-pressed
        t0 = cyc;
        sw2 = 1'b1;
        push_exp(t0 + 7, DIR_DOWN);
        wait_cyc(15);
        collided = 1'b1;
        wait_cyc(1);
        collided = 1'b0;
        wait_cyc(35);
        sw2 = 1'b0;
        wait_cyc(15);
        t1 = cyc;
        sw2 = 1'b1;
        push_exp(t1 + 7, DIR_DOWN);
        wait_cyc(12);
        sw2 = 1'b0;
        wait_cyc(15);
        check_eq("s5_queue", exp_q.size(), 0);

        // Game inactive: an edge seen while inactive never fires
        game_active = 1'b0;
        sw3 = 1'b1;
        wait_cyc(10);
        game_active = 1'b1;
        wait_cyc(15);
        sw3 = 1'b0;
        wait_cyc(10);
        check_eq("inactive_queue", exp_q.size(), 0);

        // 6: asynchronous reset while a repeat strobe is high
        t0 = cyc;
        sw4 = 1'b1;
        push_exp(t0 + 7, DIR_RIGHT);
        push_exp(t0 + 27, DIR_RIGHT);
        push_exp(t0 + 35, DIR_RIGHT);
        wait_cyc(35);
        #2;
        rst = 1'b1;
        #1;
        check_eq("s6_async_right", int'(right_mvt), 0);
        check_eq("s6_async_any", int'(any_held), 0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(12);
        check_eq("s6_rearm_any", int'(any_held), 1);
        wait_cyc(20);
        sw4 = 1'b0;
        wait_cyc(10);
        t1 = cyc;
        sw4 = 1'b1;
        push_exp(t1 + 7, DIR_RIGHT);
        wait_cyc(12);
        sw4 = 1'b0;
        wait_cyc(12);
        check_eq("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
